// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and pattern constants for the hazard pattern decoder
package hazard_pkg;

  localparam logic [2:0] PAT_A = 3'b101;
  localparam logic [2:0] PAT_B = 3'b010;
  localparam logic [2:0] PAT_C = 3'b001;
  localparam logic [2:0] PAT_D = 3'b100;

  // mode_t and xclass_t share encodings so a confirmed class maps directly onto a mode
  typedef enum logic [1:0] {
    MODE_CALM  = 2'd0,
    MODE_SEQ01 = 2'd1,
    MODE_SEQ10 = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    X_CALM    = 2'd0,
    X_SEQ01   = 2'd1,
    X_SEQ10   = 2'd2,
    X_INVALID = 2'd3
  } xclass_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } dec_state_t;

  function automatic logic is_legal(input logic [2:0] p);
    return (p == PAT_A) || (p == PAT_B) || (p == PAT_C) || (p == PAT_D);
  endfunction

endpackage

// File: rtl/hazard_pattern_decoder_if.sv
// rtl/hazard_pattern_decoder_if.sv - pattern input and recovered-mode outputs of the decoder
interface hazard_pattern_decoder_if #(
  parameter int ERR_W = 8
);
  logic             pat_valid;
  logic [2:0]       pat;
  logic [1:0]       mode;
  logic             locked;
  logic             lock_evt;
  logic             err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output pat_valid, pat,
    input  mode, locked, lock_evt, err, err_count
  );

  modport slave (
    input  pat_valid, pat,
    output mode, locked, lock_evt, err, err_count
  );
endinterface

// File: rtl/hazard_transition_classify.sv
// rtl/hazard_transition_classify.sv - combinational classification of a (prev, cur) pattern pair
module hazard_transition_classify
  import hazard_pkg::*;
(
  input  logic [2:0] prev,
  input  logic [2:0] cur,
  output xclass_t    xclass
);

  always_comb begin
    xclass = X_INVALID;
    if (is_legal(prev) && is_legal(cur)) begin
      // every legal pattern may return to A; repeats of A fall through to INVALID
      if (cur == PAT_A && prev != PAT_A) begin
        xclass = X_CALM;
      end else begin
        case ({prev, cur})
          {PAT_A, PAT_B}: xclass = X_CALM;
          {PAT_A, PAT_C},
          {PAT_C, PAT_B},
          {PAT_B, PAT_D},
          {PAT_D, PAT_C}: xclass = X_SEQ01;
          {PAT_A, PAT_D},
          {PAT_D, PAT_B},
          {PAT_B, PAT_C},
          {PAT_C, PAT_D}: xclass = X_SEQ10;
          default:        xclass = X_INVALID;
        endcase
      end
    end
  end

endmodule

// File: rtl/hazard_pattern_decoder.sv
// rtl/hazard_pattern_decoder.sv - recovers controller mode from the hazard pattern stream and flags illegal traffic
module hazard_pattern_decoder
  import hazard_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  hazard_pattern_decoder_if.slave  bus
);

  localparam int             CW    = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]  LC_V  = CW'(LOCK_COUNT);
  localparam logic [CW-1:0]  ONE_V = CW'(1);

  dec_state_t       state;
  logic [2:0]       prev_pat;
  xclass_t          cand;
  logic [CW-1:0]    cnt;
  mode_t            mode_r;
  logic             locked_r;
  logic             lock_evt_r;
  logic             err_r;
  logic [ERR_W-1:0] err_count_r;

  xclass_t          xclass;
  logic [CW-1:0]    cnt_next;
  logic [ERR_W-1:0] err_count_inc;

  hazard_transition_classify u_classify (
    .prev   (prev_pat),
    .cur    (bus.pat),
    .xclass (xclass)
  );

  // a run only continues if it was already started; cnt == 0 means history was broken
  always_comb begin
    cnt_next = ONE_V;
    if (xclass == cand && cnt != '0) begin
      cnt_next = (cnt == LC_V) ? cnt : cnt + ONE_V;
    end
  end

  assign err_count_inc = (&err_count_r) ? err_count_r : err_count_r + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      prev_pat    <= 3'b000;
      cand        <= X_CALM;
      cnt         <= '0;
      mode_r      <= MODE_CALM;
      locked_r    <= 1'b0;
      lock_evt_r  <= 1'b0;
      err_r       <= 1'b0;
      err_count_r <= '0;
    end else begin
      lock_evt_r <= 1'b0;
      err_r      <= 1'b0;
      if (bus.pat_valid) begin
        if (state == ST_IDLE) begin
          if (is_legal(bus.pat)) begin
            prev_pat <= bus.pat;
            cnt      <= '0;
            state    <= ST_TRACK;
          end else begin
            err_r       <= 1'b1;
            err_count_r <= err_count_inc;
          end
        end else if (xclass == X_INVALID) begin
          err_r       <= 1'b1;
          err_count_r <= err_count_inc;
          locked_r    <= 1'b0;
          cnt         <= '0;
          if (is_legal(bus.pat)) begin
            prev_pat <= bus.pat;
            state    <= ST_TRACK;
          end else begin
            state    <= ST_IDLE;
          end
        end else begin
          prev_pat <= bus.pat;
          cand     <= xclass;
          cnt      <= cnt_next;
          if (cnt_next == LC_V) begin
            locked_r   <= 1'b1;
            mode_r     <= mode_t'(xclass);
            state      <= ST_LOCKED;
            lock_evt_r <= !locked_r;
          end else begin
            locked_r   <= 1'b0;
            state      <= ST_TRACK;
          end
        end
      end
    end
  end

  assign bus.mode      = mode_r;
  assign bus.locked    = locked_r;
  assign bus.lock_evt  = lock_evt_r;
  assign bus.err       = err_r;
  assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_hazard_pattern_decoder.sv
// tb/tb_hazard_pattern_decoder.sv - directed-vector bench with a transition-table model of the decoder
module tb_hazard_pattern_decoder;

  localparam int LC    = 3;
  localparam int ERR_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_pattern_decoder_if #(.ERR_W(ERR_W)) bus ();

  hazard_pattern_decoder #(.LOCK_COUNT(LC), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  // class table: 0 calm, 1 seq01, 2 seq10, 3 invalid
  int cls_tab [8][8];

  bit m_have;
  int m_prev, m_run_k, m_run_len;
  int m_mode, m_locked, m_evt, m_err, m_ec;

  function automatic bit legal(input int p);
    return p == 5 || p == 2 || p == 1 || p == 4;
  endfunction

  task automatic init_table();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        cls_tab[i][j] = 3;
    foreach (cls_tab[i]) if (legal(i) && i != 5) cls_tab[i][5] = 0;
    cls_tab[5][2] = 0;
    cls_tab[5][1] = 1; cls_tab[1][2] = 1; cls_tab[2][4] = 1; cls_tab[4][1] = 1;
    cls_tab[5][4] = 2; cls_tab[4][2] = 2; cls_tab[2][1] = 2; cls_tab[1][4] = 2;
  endtask

  task automatic model(input bit v, input int p, input bit r);
    int k;
    bit now_locked;
    if (r) begin
      m_have = 0; m_prev = 0; m_run_k = 0; m_run_len = 0;
      m_mode = 0; m_locked = 0; m_evt = 0; m_err = 0; m_ec = 0;
      return;
    end
    m_evt = 0; m_err = 0;
    if (!v) return;
    if (!m_have) begin
      if (legal(p)) begin m_have = 1; m_prev = p; m_run_len = 0; end
      else m_err = 1;
    end else begin
      k = cls_tab[m_prev][p];
      if (k == 3) begin
        m_err = 1; m_run_len = 0; m_locked = 0;
        if (legal(p)) m_prev = p; else m_have = 0;
      end else begin
        m_prev = p;
        if (k == m_run_k && m_run_len > 0) m_run_len = (m_run_len + 1 > LC) ? LC : m_run_len + 1;
        else begin m_run_k = k; m_run_len = 1; end
        now_locked = (m_run_len == LC);
        if (now_locked) m_mode = m_run_k;
        m_evt = now_locked && !m_locked;
        m_locked = now_locked;
      end
    end
    if (m_err && m_ec < (1 << ERR_W) - 1) m_ec++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at vector %0d: got %0d, expected %0d", name, n_vec, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("mode",      int'(bus.mode),      m_mode);
    chk("locked",    int'(bus.locked),    m_locked);
    chk("lock_evt",  int'(bus.lock_evt),  m_evt);
    chk("err",       int'(bus.err),       m_err);
    chk("err_count", int'(bus.err_count), m_ec);
  endtask

  task automatic step(input bit v, input logic [2:0] p, input bit r);
    @(negedge clk);
    reset = r; bus.pat_valid = v; bus.pat = p;
    @(posedge clk);
    #1;
    n_vec++;
    model(v, int'(p), r);
    compare_all();
  endtask

  task automatic feed(input logic [2:0] p);
    step(1'b1, p, 1'b0);
  endtask

  initial begin
    init_table();
    reset = 1'b1; bus.pat_valid = 1'b0; bus.pat = 3'b000;
    step(0, 3'b000, 1); step(1, 3'b101, 1);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_err_count", int'(bus.err_count), 0);

    // calm lock
    feed(3'b101); feed(3'b010); feed(3'b101);
    chk("calm_prelock", int'(bus.locked), 0);
    feed(3'b010);
    chk("calm_locked", int'(bus.locked), 1);
    chk("calm_evt", int'(bus.lock_evt), 1);
    chk("calm_mode", int'(bus.mode), 0);
    feed(3'b101);
    chk("calm_evt_once", int'(bus.lock_evt), 0);

    // switch to SEQ01
    feed(3'b001);
    chk("seq01_drop", int'(bus.locked), 0);
    feed(3'b010);
    feed(3'b100);
    chk("seq01_locked", int'(bus.locked), 1);
    chk("seq01_mode", int'(bus.mode), 1);
    feed(3'b001);

    // SEQ10 then illegal pattern
    feed(3'b101); feed(3'b100); feed(3'b010);
    chk("seq10_hold_mode", int'(bus.mode), 1);
    feed(3'b001); feed(3'b100);
    chk("seq10_mode", int'(bus.mode), 2);
    feed(3'b111);
    chk("ill_err", int'(bus.err), 1);
    chk("ill_err_count", int'(bus.err_count), 1);
    chk("ill_mode_hold", int'(bus.mode), 2);

    // relock SEQ10 from IDLE, then a repeat
    feed(3'b100); feed(3'b010); feed(3'b001); feed(3'b100); feed(3'b010);
    feed(3'b010);
    chk("repeat_err", int'(bus.err), 1);
    chk("repeat_locked", int'(bus.locked), 0);
    feed(3'b001); feed(3'b100);
    chk("after_repeat_unlocked", int'(bus.locked), 0);
    feed(3'b010);
    chk("after_repeat_lock", int'(bus.locked), 1);

    // reset collides with a lock-completing sample
    step(0, 3'b000, 1);
    feed(3'b101); feed(3'b010); feed(3'b101);
    step(1, 3'b010, 1);
    chk("rst_win_locked", int'(bus.locked), 0);
    chk("rst_win_evt", int'(bus.lock_evt), 0);
    chk("rst_win_mode", int'(bus.mode), 0);

    // gaps in the middle of a lock sequence
    feed(3'b101); feed(3'b010);
    for (int i = 0; i < 5; i++) step(0, 3'b110, 0);
    feed(3'b101);
    chk("gap_not_yet", int'(bus.locked), 0);
    feed(3'b010);
    chk("gap_locked", int'(bus.locked), 1);

    // illegal patterns while IDLE, including saturation of the error counter
    step(0, 3'b000, 1);
    feed(3'b000);
    chk("idle_ill_err", int'(bus.err), 1);
    for (int i = 0; i < 260; i++) feed((i % 2 == 0) ? 3'b011 : 3'b110);
    chk("err_sat", int'(bus.err_count), 255);
    feed(3'b101);
    chk("legal_after_sat", int'(bus.err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
